fft_butterfly_tw_stage: RTL and testbench
=========================================

# fft_butterfly_tw_stage

Radix-2 decimation butterfly stage that consumes twiddle factors from the real and imaginary twiddle ROMs and produces butterfly outputs for the CWT frequency-domain path. It accepts (a, b) complex operand pairs over a valid/ready handshake. It generates the ROM address from an internal butterfly counter and computes x = a + b·W and y = a − b·W in Q8.8. Results go out over a valid/ready handshake with a frame-last marker. The block sits directly upstream of the twiddle ROMs, which it addresses, and feeds the downstream accumulator/IFFT buffer.

## Interface
- DATA_W, 16, operand/twiddle/result width (signed Q8.8)
- FRAC_W, 8, fractional bits of twiddle and operands
- ADDR_W, 5, twiddle ROM address width
- NUM_TW, 28, butterflies per frame (ROM entries 0..27)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair this cycle
- in_a_re, in_a_im, in_b_re, in_b_im  in  DATA_W each  signed operands
- tw_addr  out  ADDR_W  address to both twiddle ROMs (1-cycle registered-read ROMs)
- tw_re, tw_im  in  DATA_W each  ROM data, valid one edge after tw_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_x_re, out_x_im, out_y_re, out_y_im  out  DATA_W each  results
- out_last  out  1  result belongs to butterfly index NUM_TW−1
- busy  out  1  any pipeline stage holds valid data

## Operation
- Pipeline: S1 (capture a, b, idx), S2 (ROM read in flight), S3 (complex product), OUT (add/sub). Each stage has its own valid bit. Bubbles are allowed.
- Global enable en = !out_valid || out_ready. in_ready = en. Accept on in_valid && in_ready.
- idx counter: 0..NUM_TW−1. Increments on each accept and wraps to 0 after NUM_TW−1. idx travels with the data; the last flag is set when idx == NUM_TW−1.
- tw_addr = en ? S1.idx : S2.idx (combinational). During a stall the ROM therefore keeps presenting the S2 item's twiddle. The combinational path out_ready→tw_addr is intended.
- S3 product, computed on the S2→S3 edge from tw_re/tw_im:
  - p_re = b_re·tw_re − b_im·tw_im
  - p_im = b_re·tw_im + b_im·tw_re
  - Full 33-bit intermediates, add 2^(FRAC_W−1), arithmetic shift right by FRAC_W, reduce to DATA_W (see Configuration).
- OUT: x = a + p, y = a − p, computed at DATA_W+1 bits and reduced to DATA_W (see Configuration).
- When en = 0, all stage registers, the idx counter and the valid bits hold.
- Reset values:
  - in the pipeline: all valid bits 0, idx 0
  - on the outputs: out_valid 0, out_last 0, busy 0, all out_* data 0x0000
  - tw_addr = 0 after reset

## Timing
- Latency: a pair accepted at edge E0 is presented with out_valid = 1 after edge E3, i.e. 3 cycles later, when there are no stalls.
- Throughput: 1 pair/cycle while out_ready = 1.
- Output holds stable while out_valid && !out_ready. No data loss and no duplication.
- in_valid with in_ready low: no accept, idx unchanged.
- Simultaneous accept and output transfer in the same cycle: both occur.
- Wrap: the accept at idx = 27 issues tw_addr 27 and the next accept issues 0. out_last is high only on the index-27 result.
- rst asserted mid-frame: pipeline flushed, idx returns to 0 on the next edge, in-flight results discarded.

## Configuration
- FFT_BF_SATURATE_EN defined:
  - product reduction and x/y reduction saturate to [0x8000, 0x7FFF]
- FFT_BF_SATURATE_EN undefined:
  - product reduction and x/y reduction keep the low DATA_W bits (two's-complement wrap)
  - rounding is unchanged

## Test plan
- Reset, then accept a=(0x0100,0), b=(0x0100,0) at idx 0 with tw=(0x0100,0x0000) → x=(0x0200,0x0000), y=(0x0000,0x0000), out_valid 3 cycles after accept, tw_addr=0.
- 28 back-to-back accepts with out_ready=1 → tw_addr steps 0..27 then wraps to 0; exactly one out_last, on the 28th result; busy drops 3 cycles after the last accept.
- idx 9 with tw_re=0x00B5, tw_im=0xFF4B, a=0, b=(0x0100,0) → x=(0x00B5,0xFF4B), y=(0xFF4B,0x00B5).
- Hold out_ready=0 for 5 cycles with the pipeline full → outputs frozen, in_ready=0, tw_addr held at the S2 index; on release, results continue in order with correct twiddles.
- a=(0x7F00,0), b=(0x7F00,0), tw=(0x0100,0) → x_re=0x7FFF with FFT_BF_SATURATE_EN, 0xFE00 without.
- Assert rst for one cycle mid-frame → next edge: out_valid=0, busy=0; next accept uses tw_addr=0.

Source files
------------

// File: rtl/fft_butterfly_tw_stage.sv
// fft_butterfly_tw_stage: radix-2 butterfly x = a + b*W, y = a - b*W in Q8.8.
// The twiddle W comes from two external registered-read ROMs that this block addresses.
// Latency: 3 cycles from accept to out_valid. Throughput: 1 pair/cycle.
// Backpressure: one global enable stalls every stage while out_valid && !out_ready.
//
// Optional build macro FFT_BF_SATURATE_EN:
//   defined   - the product and x/y reductions clamp to [0x8000, 0x7FFF]
//   undefined - the product and x/y reductions keep the low DATA_W bits
//               (two's-complement wrap); rounding is the same in both builds
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready                 operand-pair handshake
//   in_a_re/in_a_im/in_b_re/in_b_im   signed Q8.8 operands a and b
//   tw_addr                           twiddle ROM address (combinational)
//   tw_re/tw_im                       ROM data, valid one edge after tw_addr
//   out_valid/out_ready               result handshake
//   out_x_re/out_x_im/out_y_re/out_y_im  results x and y
//   out_last                          result of butterfly NUM_TW-1
//   busy                              S1, S2 or S3 holds an item
module fft_butterfly_tw_stage #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ADDR_W = 5,
  parameter int NUM_TW = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a_re,
  input  logic [DATA_W-1:0] in_a_im,
  input  logic [DATA_W-1:0] in_b_re,
  input  logic [DATA_W-1:0] in_b_im,
  output logic [ADDR_W-1:0] tw_addr,
  input  logic [DATA_W-1:0] tw_re,
  input  logic [DATA_W-1:0] tw_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x_re,
  output logic [DATA_W-1:0] out_x_im,
  output logic [DATA_W-1:0] out_y_re,
  output logic [DATA_W-1:0] out_y_im,
  output logic              out_last,
  output logic              busy
);

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;

  // Working width: a full DATA_W x DATA_W product difference plus a sign bit.
  localparam int WW = 2*DATA_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TW - 1);
  localparam logic signed [WW-1:0] RND = WW'(1) << (FRAC_W - 1);

  function automatic logic signed [WW-1:0] sx(input logic [DATA_W-1:0] v);
    return {{(DATA_W+1){v[DATA_W-1]}}, v};
  endfunction

  // Reduce a WW-bit signed value to DATA_W bits: clamp or wrap.
  function automatic logic [DATA_W-1:0] reduce(input logic signed [WW-1:0] v);
`ifdef FFT_BF_SATURATE_EN
    logic signed [WW-1:0] sat_max;
    logic signed [WW-1:0] sat_min;
    sat_max = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    sat_min = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > sat_max)      return sat_max[DATA_W-1:0];
    else if (v < sat_min) return sat_min[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Pipeline state
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              s1_vld_q, s2_vld_q, s3_vld_q, out_valid_q, out_last_q;
  cplx_t             s1_a_q, s1_b_q, s2_a_q, s2_b_q, s3_a_q, s3_p_q;
  logic [ADDR_W-1:0] s1_idx_q, s2_idx_q, s3_idx_q;
  cplx_t             out_x_q, out_y_q;

  logic              en, accept;
  logic signed [WW-1:0] prod_re, prod_im;
  cplx_t             p_d, x_d, y_d;

  assign en       = !out_valid_q || out_ready;
  assign accept   = in_valid && en;
  assign in_ready = en;

  // While stalled the ROM must keep returning the S2 item's twiddle, because
  // that item consumes tw_re/tw_im on the edge that finally advances it.
  assign tw_addr = en ? s1_idx_q : s2_idx_q;

  assign idx_d = !accept           ? idx_q :
                 (idx_q == LAST_IDX) ? '0   : idx_q + 1'b1;

  always_comb begin
    prod_re = sx(s2_b_q.re) * sx(tw_re) - sx(s2_b_q.im) * sx(tw_im);
    prod_im = sx(s2_b_q.re) * sx(tw_im) + sx(s2_b_q.im) * sx(tw_re);
    // Round half up, then drop the fractional bits of the twiddle.
    p_d.re  = reduce((prod_re + RND) >>> FRAC_W);
    p_d.im  = reduce((prod_im + RND) >>> FRAC_W);
    x_d.re  = reduce(sx(s3_a_q.re) + sx(s3_p_q.re));
    x_d.im  = reduce(sx(s3_a_q.im) + sx(s3_p_q.im));
    y_d.re  = reduce(sx(s3_a_q.re) - sx(s3_p_q.re));
    y_d.im  = reduce(sx(s3_a_q.im) - sx(s3_p_q.im));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_idx_q    <= '0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_idx_q    <= '0;
      s3_a_q      <= '0;
      s3_p_q      <= '0;
      s3_idx_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else if (en) begin
      idx_q    <= idx_d;
      // S1: capture operands and the butterfly index they belong to
      s1_vld_q <= in_valid;
      if (accept) begin
        s1_a_q   <= '{re: in_a_re, im: in_a_im};
        s1_b_q   <= '{re: in_b_re, im: in_b_im};
        s1_idx_q <= idx_q;
      end
      // S2: ROM read for s1_idx_q is in flight
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_a_q   <= s1_a_q;
        s2_b_q   <= s1_b_q;
        s2_idx_q <= s1_idx_q;
      end
      // S3: complex product b*W using the ROM data now on tw_re/tw_im
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) begin
        s3_a_q   <= s2_a_q;
        s3_p_q   <= p_d;
        s3_idx_q <= s2_idx_q;
      end
      // OUT: add/subtract; data only reloads for real items
      out_valid_q <= s3_vld_q;
      out_last_q  <= s3_vld_q && (s3_idx_q == LAST_IDX);
      if (s3_vld_q) begin
        out_x_q <= x_d;
        out_y_q <= y_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_x_re  = out_x_q.re;
  assign out_x_im  = out_x_q.im;
  assign out_y_re  = out_y_q.re;
  assign out_y_im  = out_y_q.im;
  // The OUT register's occupancy is already visible as out_valid.
  assign busy      = s1_vld_q | s2_vld_q | s3_vld_q;

endmodule

// File: tb/tb_fft_butterfly_tw_stage.sv
module tb_fft_butterfly_tw_stage;

`ifdef FFT_BF_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [15:0] in_a_re, in_a_im, in_b_re, in_b_im;
  logic [15:0] tw_re, tw_im;
  logic [15:0] out_x_re, out_x_im, out_y_re, out_y_im;
  logic [4:0]  tw_addr;

  always #5 clk = ~clk;

  fft_butterfly_tw_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
    .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x_re(out_x_re), .out_x_im(out_x_im), .out_y_re(out_y_re), .out_y_im(out_y_im),
    .out_last(out_last), .busy(busy)
  );

  // Registered-read twiddle ROMs
  logic [15:0] rom_re [32];
  logic [15:0] rom_im [32];
  always @(posedge clk) begin
    tw_re <= rom_re[tw_addr];
    tw_im <= rom_im[tw_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference butterfly in plain integer arithmetic
  typedef struct {
    logic [15:0] xr, xi, yr, yi;
    logic        last;
  } res_t;

  function automatic logic [15:0] red(input longint v);
    if (SAT && v > 32767)  return 16'h7FFF;
    if (SAT && v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  function automatic res_t model(input logic signed [15:0] ar, ai, br, bi, tr, ti,
                                 input int idx);
    res_t r;
    logic signed [15:0] pr, pi;
    pr = red(((longint'(br) * tr) - (longint'(bi) * ti) + 128) >>> 8);
    pi = red(((longint'(br) * ti) + (longint'(bi) * tr) + 128) >>> 8);
    r.xr = red(longint'(ar) + longint'(pr));
    r.xi = red(longint'(ai) + longint'(pi));
    r.yr = red(longint'(ar) - longint'(pr));
    r.yi = red(longint'(ai) - longint'(pi));
    r.last = (idx == 27);
    return r;
  endfunction

  // Scoreboard monitor: pushes on accept, pops on output transfer
  res_t sb[$];
  bit   sb_on = 1'b0;
  int   exp_idx = 0, prev_idx = 0, out_cnt = 0, last_cnt = 0;
  bit   prev_acc = 1'b0;

  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      sb.delete();
      exp_idx  = 0;
      prev_acc = 1'b0;
    end else if (sb_on) begin
      if (prev_acc && in_ready) chk("mon_tw_addr", tw_addr, prev_idx);
      if (out_valid && out_ready) begin
        out_cnt++;
        if (out_last) last_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mon_unexpected_output actual=x_re %0h required=no output", out_x_re);
        end else begin
          e = sb.pop_front();
          chk("mon_x_re", out_x_re, e.xr);
          chk("mon_x_im", out_x_im, e.xi);
          chk("mon_y_re", out_y_re, e.yr);
          chk("mon_y_im", out_y_im, e.yi);
          chk("mon_last", out_last, e.last);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a_re, in_a_im, in_b_re, in_b_im,
                           rom_re[exp_idx], rom_im[exp_idx], exp_idx));
        prev_idx = exp_idx;
        exp_idx  = (exp_idx == 27) ? 0 : exp_idx + 1;
        prev_acc = 1'b1;
      end else begin
        prev_acc = 1'b0;
      end
    end
  end

  task automatic drive(input int k);
    in_a_re = 16'(k * 64);
    in_a_im = 16'(-k * 16);
    in_b_re = 16'(256 + k * 32);
    in_b_im = 16'(768 - k * 48);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // a_re, a_im, b_re, b_im, tw_re, tw_im, x_re, x_im, y_re, y_im
  typedef struct {
    logic [15:0] a_re, a_im, b_re, b_im, tw_re, tw_im, x_re, x_im, y_re, y_im;
  } vec_t;
  vec_t vt[10];

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0;
    for (int k = 0; k < 32; k++) begin rom_re[k] = 16'h0100; rom_im[k] = 16'h0000; end

    vt[0] = '{16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000,
              16'h0200, 16'h0000, 16'h0000, 16'h0000};
    vt[1] = '{16'h0000, 16'h0000, 16'h0100, 16'h0200, 16'h0000, 16'h0100,
              16'hFE00, 16'h0100, 16'h0200, 16'hFF00};
    vt[2] = '{16'h0300, 16'hFD00, 16'h0080, 16'h0000, 16'h0100, 16'h0000,
              16'h0380, 16'hFD00, 16'h0280, 16'hFD00};
    vt[3] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0080, 16'h0000,
              16'h0001, 16'h0000, 16'hFFFF, 16'h0000};
    vt[4] = '{16'h0010, 16'h0020, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000,
              16'h0010, 16'h0020, 16'h0010, 16'h0020};
    vt[5] = '{16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000,
              SAT ? 16'h7FFF : 16'hFE00, 16'h0000, 16'h0000, 16'h0000};
    vt[6] = '{16'h8000, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000,
              16'h8100, 16'h0000, SAT ? 16'h8000 : 16'h7F00, 16'h0000};
    vt[7] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000,
              SAT ? 16'h7FFF : 16'hFF00, 16'h0000, SAT ? 16'h8001 : 16'h0100, 16'h0000};
    vt[8] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
              16'h0100, 16'h0300, 16'h0100, 16'hFF00};
    vt[9] = '{16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h00B5, 16'hFF4B,
              16'h00B5, 16'hFF4B, 16'hFF4B, 16'h00B5};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", {out_x_re, out_x_im, out_y_re, out_y_im}, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Table: one isolated butterfly per entry, entry i lands on idx i
    for (int i = 0; i < 10; i++) begin
      rom_re[i] = vt[i].tw_re;
      rom_im[i] = vt[i].tw_im;
      in_a_re = vt[i].a_re; in_a_im = vt[i].a_im;
      in_b_re = vt[i].b_re; in_b_im = vt[i].b_im;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("tab%0d_tw_addr", i), tw_addr, i);
      lat = 0;
      while (!out_valid && lat < 8) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("tab%0d_latency", i), lat, 3);
      chk($sformatf("tab%0d_x_re", i), out_x_re, vt[i].x_re);
      chk($sformatf("tab%0d_x_im", i), out_x_im, vt[i].x_im);
      chk($sformatf("tab%0d_y_re", i), out_y_re, vt[i].y_re);
      chk($sformatf("tab%0d_y_im", i), out_y_im, vt[i].y_im);
      chk($sformatf("tab%0d_last", i), out_last, 0);
      @(posedge clk); #1;
    end

    // Distinct twiddles per index for the streaming sequences
    for (int k = 0; k < 32; k++) begin
      rom_re[k] = 16'(256 - k * 8);
      rom_im[k] = 16'(k * 17 - 128);
    end
    sb_on = 1'b1;

    // 30 back-to-back accepts: idx 0..27 then wrap to 0, 1
    do_reset();
    out_cnt = 0; last_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      drive(k);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("burst_busy_el0", busy, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("burst_busy_el2", busy, 1);
    @(posedge clk); #1;
    chk("burst_busy_el3", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("burst_out_cnt", out_cnt, 30);
    chk("burst_last_cnt", last_cnt, 1);
    chk("burst_sb_empty", sb.size(), 0);

    // Stall with a full pipeline: OUT=0, S3=1, S2=2, S1=3
    do_reset();
    out_cnt = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(k);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    drive(4);
    for (int c = 0; c < 5; c++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_tw_addr", tw_addr, 2);
      if (sb.size() != 5 - 1) chk("stall_sb_depth", sb.size(), 4);
      else begin
        chk("stall_x_re", out_x_re, sb[0].xr);
        chk("stall_y_im", out_y_im, sb[0].yi);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("stall_out_cnt", out_cnt, 5);
    chk("stall_sb_empty", sb.size(), 0);

    // Reset mid-frame discards in-flight items and restarts idx at 0
    do_reset();
    out_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      drive(k + 7);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    do_reset();
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_tw_addr", tw_addr, 0);
    out_cnt = 0;
    drive(11);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mrst_next_tw_addr", tw_addr, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("mrst_out_cnt", out_cnt, 1);
    chk("mrst_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
